lfsr16: RTL and testbench
=========================

Name: lfsr16

Overview:
- 16-bit maximal-length Fibonacci LFSR pseudo-random sequence generator.
- Advances one step per clock while enabled and holds otherwise.
- Used as a lightweight PRBS / test-pattern source. It has no handshake.
- The full state is exposed directly as the output word.

Parameters:
SEED  16'hACE1  state loaded on reset; must be nonzero (a zero value is replaced by 16'h0001 at elaboration)

Ports:
clk      input   1   rising-edge clock, the only clock
reset_n  input   1   synchronous, active-low reset
enable   input   1   advance the LFSR by one step on this clock edge when high
lfsr     output  16  current LFSR state, driven directly from the state register

Behaviour:
- Single clock domain. All state changes occur on the rising edge of clk.
- Reset is synchronous and active-low:
  - If reset_n=0 at a rising edge, lfsr <= SEED, regardless of enable.
  - Reset has priority over enable.
- Before the first reset edge the state is undefined (X in simulation). No initial value is required.
- Polynomial: x^16 + x^14 + x^13 + x^11 + 1 (taps 16,14,13,11), which gives a maximal period of 65535.
- Step, applied when reset_n=1 and enable=1 at a rising edge:
  - fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10] (XOR form).
  - lfsr <= {lfsr[14:0], fb}, i.e. shift left with feedback into bit 0.
- Hold: when reset_n=1 and enable=0, lfsr keeps its value.
- Latency: the output changes in the same cycle as the sampled enable. The new value is visible immediately after the edge, with no pipeline stage.
- The output is purely registered. There is no combinational path from the inputs to lfsr.
- Lockup guard:
  - The all-zero state is illegal.
  - If the state register ever reads 16'h0000 while reset_n=1, the next edge loads SEED, regardless of enable.
  - This state is unreachable in normal operation.
- Sequence from SEED=16'hACE1: ACE1 -> 59C3 -> B387 -> 670F -> CE1E -> ...
- Period: exactly 65535 enabled steps return the state to SEED. No intermediate state equals SEED or 0.
- Reset mid-sequence: the next rising edge with reset_n=0 reloads SEED. Stepping resumes from SEED on the first enabled edge after reset_n returns high.
- enable has no minimum pulse width. Each enabled edge produces exactly one step.

Test Plan:
- Reset: hold reset_n=0 with enable at 0 and at 1 for 2 edges -> lfsr = 0xACE1 after the first edge; it stays 0xACE1.
- Hold: release reset with enable=0 for 2 edges -> lfsr remains 0xACE1.
- Stepping: enable=1 for 4 edges -> lfsr = 59C3, B387, 670F, CE1E on successive edges.
- Enable gap: enable=0 for 3 edges, then enable=1 for 1 edge -> value frozen at the last state, then advances by exactly one step.
- Reset mid-operation: after ~10 enabled steps, assert reset_n=0 for 1 edge with enable=1 -> lfsr = 0xACE1, then resumes with 59C3.
- Full period: enable continuously for 65535 edges from SEED -> returns to 0xACE1 exactly at step 65535; 0x0000 and 0xACE1 never occur before then; all 65535 nonzero values are seen once.

Source files
------------

// File: rtl/lfsr16.sv
// lfsr16: 16-bit maximal-length Fibonacci LFSR, x^16 + x^14 + x^13 + x^11 + 1.
// Latency: a step is visible immediately after the enabled edge; the output comes straight from the state flop.
// Backpressure: none. There is no handshake; enable gates stepping and the word is always valid after reset.
//
// Ports:
//   clk      rising-edge clock, the only clock
//   reset_n  synchronous active-low reset; loads SEED and has priority over enable
//   enable   advance one step on this edge when high, hold when low
//   lfsr     current 16-bit state
module lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic [15:0] lfsr
);

  // A zero seed would lock the register at zero forever, so substitute 1.
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;
  logic        fb;

  always_comb begin
    fb     = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d = lfsr_q;
    if (lfsr_q == 16'h0000) begin
      // All-zero is the one state the XOR feedback can never leave; recover to SEED.
      lfsr_d = SEED_EFF;
    end else if (enable) begin
      lfsr_d = {lfsr_q[14:0], fb};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lfsr_q <= SEED_EFF;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr = lfsr_q;

endmodule

// File: tb/tb_lfsr16.sv
// tb_lfsr16: bench for lfsr16 with a behavioural reference model and directed vectors.
// Latency: outputs compared on every falling edge once a reset edge has defined the state.
// Backpressure: not applicable.
module tb_lfsr16;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [15:0] lfsr;

  int vectors = 0;
  int errors  = 0;

  lfsr16 #(.SEED(16'hACE1)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .lfsr    (lfsr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: tap positions 16,14,13,11 map to bits 15,13,12,10 (mask 0xB400);
  // the feedback bit is the parity of the tapped bits.
  logic [15:0] model;
  logic        model_vld = 1'b0;

  function automatic logic [15:0] poly_step(input logic [15:0] s);
    logic [15:0] t;
    int          ones;
    t    = s & 16'hB400;
    ones = 0;
    for (int k = 0; k < 16; k++) ones += int'(t[k]);
    return (s << 1) | {15'd0, ones[0]};
  endfunction

  always @(posedge clk) begin
    if (reset_n === 1'b0) begin
      model     <= 16'hACE1;
      model_vld <= 1'b1;
    end else if (model_vld) begin
      if (model == 16'h0000)    model <= 16'hACE1;
      else if (enable === 1'b1) model <= poly_step(model);
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    if (model_vld) begin
      vectors++;
      if (lfsr !== model) begin
        errors++;
        $display("FAIL model_cmp t=%0t got=%h exp=%h", $time, lfsr, model);
      end
    end
  end

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Drive inputs, take one rising edge, then settle just after it.
  task automatic edge_step(input logic r, input logic e);
    reset_n = r;
    enable  = e;
    @(posedge clk);
    #2;
  endtask

  bit          seen [65536];
  int          bad;
  int          uniq;
  logic [15:0] held;

  initial begin
    reset_n = 1'b1;
    enable  = 1'b0;

    // Reset with enable low and high.
    edge_step(1'b0, 1'b0); check("reset_en0", lfsr, 16'hACE1);
    edge_step(1'b0, 1'b1); check("reset_en1", lfsr, 16'hACE1);

    // Hold after release.
    edge_step(1'b1, 1'b0); check("hold_1", lfsr, 16'hACE1);
    edge_step(1'b1, 1'b0); check("hold_2", lfsr, 16'hACE1);

    // First steps from the seed.
    edge_step(1'b1, 1'b1); check("step_1", lfsr, 16'h59C3);
    edge_step(1'b1, 1'b1); check("step_2", lfsr, 16'hB387);
    edge_step(1'b1, 1'b1); check("step_3", lfsr, 16'h670F);
    edge_step(1'b1, 1'b1); check("step_4", lfsr, 16'hCE1E);

    // Enable gap then a single step.
    for (int i = 0; i < 3; i++) begin
      edge_step(1'b1, 1'b0); check("gap_hold", lfsr, 16'hCE1E);
    end
    edge_step(1'b1, 1'b1); check("gap_step", lfsr, 16'h9C3C);

    // Alternating single-cycle enable pulses: each pulse is exactly one step.
    for (int i = 0; i < 6; i++) begin
      held = lfsr;
      edge_step(1'b1, 1'b1); check("pulse_step", lfsr, poly_step(held));
      held = lfsr;
      edge_step(1'b1, 1'b0); check("pulse_hold", lfsr, held);
    end

    // Reset mid-sequence with enable high, then resume.
    for (int i = 0; i < 10; i++) edge_step(1'b1, 1'b1);
    edge_step(1'b0, 1'b1); check("mid_reset", lfsr, 16'hACE1);
    edge_step(1'b1, 1'b1); check("resume", lfsr, 16'h59C3);

    // Full period from the seed.
    edge_step(1'b0, 1'b0); check("period_reset", lfsr, 16'hACE1);
    for (int v = 0; v < 65536; v++) seen[v] = 1'b0;
    bad  = 0;
    uniq = 0;
    reset_n = 1'b1;
    enable  = 1'b1;
    for (int i = 1; i <= 65535; i++) begin
      @(posedge clk);
      #2;
      if (i < 65535 && (lfsr == 16'hACE1 || lfsr == 16'h0000)) bad++;
      if (lfsr === 16'hxxxx || seen[lfsr]) bad++;
      else begin
        seen[lfsr] = 1'b1;
        uniq++;
      end
    end
    check("period_end", lfsr, 16'hACE1);
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL period_bad_states got=%0d exp=0", bad);
    end
    vectors++;
    if (uniq != 65535) begin
      errors++;
      $display("FAIL period_unique got=%0d exp=65535", uniq);
    end
    vectors++;
    if (seen[0]) begin
      errors++;
      $display("FAIL period_zero_seen got=1 exp=0");
    end

    enable = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
